tff_chain_arb: RTL and testbench

Round-robin arbiter and sequencer sharing one serial T-flip-flop toggle chain among NREQ requesters. A granted requester asks for a number of toggle pulses. The block drives the chain's shared T input high for exactly that many cycles, holds it low while the chain settles, then signals completion. It sits directly in front of the cascaded T-flip-flop datapath and is its only driver.

---
 rtl/tff_chain_pkg.sv | 20 ++
 rtl/tff_chain_arb_rr_pick.sv | 30 +++
 rtl/tff_chain_arb.sv | 163 ++++++++++++++++
 tb/tb_tff_chain_arb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_chain_pkg.sv
// Shared types and defaults for the T-flip-flop chain arbiter and its helpers.
package tff_chain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned LAT_DEF   = 2;

  // Width of an index able to address n items, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tff_chain_arb_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr_i,
// wrapping. Returns one-hot, binary index and an any-request flag.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW-1:0] j;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    j        = '0;
    for (int unsigned off = 0; off < N; off++) begin
      j = IW'((32'(ptr_i) + off) % N);
      if (!any_o && req_i[j]) begin
        onehot_o[j] = 1'b1;
        idx_o       = j;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tff_chain_arb.sv
// Round-robin arbiter/sequencer driving the shared T input of a serial TFF chain.
// Optional shadow chain checker enabled by defining TFF_CHAIN_ARB_SHADOW_EN.
module tff_chain_arb
  import tff_chain_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LAT   = LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] cnt,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  t_out,
  output logic                  busy,
  input  logic                  q_chain,
  output logic                  err
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned SW = idx_w(LAT);

  state_e state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [SW-1:0]    settle_q, settle_d;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            t_out_q, t_out_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0]  pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [CNT_W-1:0] cnt_sel;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    cnt_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) cnt_sel = cnt[i*CNT_W +: CNT_W];
    end
  end

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      rem_q    <= '0;
      settle_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      t_out_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      rem_q    <= rem_d;
      settle_q <= settle_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      t_out_q  <= t_out_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    rem_d    = rem_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gidx_d   = pick_idx;
          rem_d    = cnt_sel;
          settle_d = '0;
          state_d  = (cnt_sel != '0) ? ISSUE : DRAIN;
        end
      end
      ISSUE: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d  = DRAIN;
          settle_d = '0;
        end
      end
      DRAIN: begin
        if (settle_q == SW'(LAT - 1)) state_d = DONE;
        else                          settle_d = settle_q + SW'(1);
      end
      DONE: begin
        ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they appear registered
  // in the same cycle as the state they describe.
  always_comb begin
    gnt_d   = gnt_q;
    done_d  = '0;
    t_out_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
    if (state_d == IDLE)      gnt_d = '0;
    else if (state_q == IDLE) gnt_d = pick_onehot;
    if (state_d == DONE) done_d = gnt_q;
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign t_out = t_out_q;
  assign busy  = busy_q;

`ifdef TFF_CHAIN_ARB_SHADOW_EN
  logic [LAT-1:0] sh_q, sh_d;
  logic           err_q, err_d;

  always_comb begin
    sh_d    = sh_q;
    sh_d[0] = sh_q[0] ^ t_out_q;
    for (int unsigned k = 1; k < LAT; k++) sh_d[k] = sh_q[k] ^ sh_q[k-1];
    err_d = err_q | ((state_q == DONE) && (q_chain != sh_q[LAT-1]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_q_chain;
  assign unused_q_chain = q_chain;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tff_chain_arb.sv
// Self-checking bench for tff_chain_arb: cycle model plus directed scenarios.
module tb_tff_chain_arb;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;
  localparam int LAT   = 2;
`ifdef TFF_CHAIN_ARB_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*CNT_W-1:0] cnt = '0;
  logic [NREQ-1:0]       gnt, done;
  logic                  t_out, busy, err, q_chain;
  logic                  inv = 1'b0;
  logic [LAT-1:0]        chain;

  tff_chain_arb #(.NREQ(NREQ), .CNT_W(CNT_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .cnt(cnt), .gnt(gnt), .done(done),
    .t_out(t_out), .busy(busy), .q_chain(q_chain), .err(err)
  );

  always #5 clk = ~clk;

  // Downstream chain: stage 0 toggles on T, each later stage toggles on the one before.
  always @(posedge clk) begin
    if (rst) chain <= '0;
    else begin
      chain[0] <= chain[0] ^ t_out;
      for (int k = 1; k < LAT; k++) chain[k] <= chain[k] ^ chain[k-1];
    end
  end
  assign q_chain = chain[LAT-1] ^ inv;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a grant occupies cnt+LAT+1 cycles, pulses T for the first cnt, done on the last,
  // then one idle cycle before the next round-robin choice.
  bit m_act;
  int m_g, m_c, m_len, m_pos, m_ptr;
  logic [NREQ-1:0] e_gnt, e_done;
  logic e_t, e_busy, e_err;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_ptr = 0; m_pos = 0; m_g = 0; m_c = 0; m_len = 0;
      e_err = 1'b0;
    end else begin
      if (SHADOW && e_done != 0 && inv) e_err = 1'b1;
      if (m_act) begin
        m_pos++;
        if (m_pos == m_len) begin
          m_act = 0;
          m_ptr = (m_g + 1) % NREQ;
        end
      end else if (req != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req[(m_ptr + k) % NREQ]) begin
            m_g = (m_ptr + k) % NREQ;
            break;
          end
        end
        m_c   = int'(cnt[m_g*CNT_W +: CNT_W]);
        m_len = m_c + LAT + 1;
        m_pos = 0;
        m_act = 1;
      end
    end
    e_gnt  = m_act ? NREQ'(1) << m_g : '0;
    e_t    = m_act && (m_pos < m_c);
    e_done = (m_act && m_pos == m_len - 1) ? NREQ'(1) << m_g : '0;
    e_busy = m_act;
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("done", 32'(done), 32'(e_done));
      chk("t_out", 32'(t_out), 32'(e_t));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("err", 32'(err), 32'(e_err));
    end
  end

  // Monitor records each grant: index, raw value, start cycle, length, T pulses.
  int cyc = 0, done_total = 0, tc_cur = 0;
  int g_idx[$], g_val[$], g_start[$], g_len[$], g_tc[$];
  logic [NREQ-1:0] gnt_prev = '0;

  always @(negedge clk) begin
    cyc++;
    if (gnt != 0 && gnt_prev == 0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) g_idx.push_back(i);
      g_val.push_back(int'(gnt));
      g_start.push_back(cyc);
      tc_cur = 0;
    end
    if (gnt != 0 && t_out) tc_cur++;
    if (gnt == 0 && gnt_prev != 0) begin
      g_len.push_back(cyc - g_start[g_start.size()-1]);
      g_tc.push_back(tc_cur);
    end
    if (done != 0) done_total++;
    gnt_prev = gnt;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n);
    int budget = 200;
    while (g_len.size() < n && budget > 0) begin
      step();
      budget--;
    end
    chk("wait_grants", 32'(g_len.size()), 32'(n));
  endtask

  task automatic wait_done(input int i);
    int budget = 100;
    while (!done[i] && budget > 0) begin
      step();
      budget--;
    end
    chk("wait_done", 32'(done[i]), 32'd1);
  endtask

  initial begin
    int base;
    @(posedge clk);
    chk_en = 1;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_t_out", 32'(t_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single request, cnt = 5.
    cnt[2*CNT_W +: CNT_W] = 8'd5;
    req = 4'b0100;
    wait_grants(1);
    req = '0;
    chk("single_idx", 32'(g_idx[0]), 32'd2);
    chk("single_gnt", 32'(g_val[0]), 32'h4);
    chk("single_len", 32'(g_len[0]), 32'd8);
    chk("single_tpulses", 32'(g_tc[0]), 32'd5);

    // Zero count.
    cnt[0 +: CNT_W] = 8'd0;
    req = 4'b0001;
    wait_grants(2);
    req = '0;
    chk("zero_idx", 32'(g_idx[1]), 32'd0);
    chk("zero_len", 32'(g_len[1]), 32'd3);
    chk("zero_tpulses", 32'(g_tc[1]), 32'd0);

    // Reset mid-ISSUE with cnt = 10; ptr is 1 beforehand, so grant goes to 2.
    cnt[2*CNT_W +: CNT_W] = 8'd10;
    req = 4'b0100;
    begin
      int budget = 20;
      while (!t_out && budget > 0) begin step(); budget--; end
    end
    repeat (2) step();
    base = done_total;
    rst = 1'b1;
    req = '0;
    step();
    chk("abort_t_out", 32'(t_out), 32'd0);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (15) step();
    chk("abort_no_done", 32'(done_total), 32'(base));
    chk("abort_idx", 32'(g_idx[2]), 32'd2);

    // Fairness: all requesting with cnt = 1; ptr restarted at 0 by reset.
    for (int i = 0; i < NREQ; i++) cnt[i*CNT_W +: CNT_W] = 8'd1;
    req = 4'b1111;
    wait_grants(8);
    req = '0;
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        chk("fair_order", 32'(g_idx[3+k]), 32'(order[k]));
        chk("fair_len", 32'(g_len[3+k]), 32'd4);
      end
      for (int k = 3; k < 7; k++)
        chk("fair_gap", 32'(g_start[k+1] - g_start[k] - g_len[k]), 32'd1);
    end

    // Wrap-around: grant 3, then 4'b1001 must serve 0 before 3.
    cnt[3*CNT_W +: CNT_W] = 8'd2;
    req = 4'b1000;
    wait_grants(9);
    req = 4'b1001;
    wait_done(0);
    req = 4'b1000;
    wait_grants(11);
    req = '0;
    chk("wrap_first", 32'(g_idx[8]), 32'd3);
    chk("wrap_second", 32'(g_idx[9]), 32'd0);
    chk("wrap_third", 32'(g_idx[10]), 32'd3);

    // Shadow: a clean run leaves err low, an inverted chain during DONE latches it.
    cnt[2*CNT_W +: CNT_W] = 8'd3;
    req = 4'b0100;
    wait_grants(12);
    chk("shadow_clean", 32'(err), 32'd0);
    wait_done(2);
    inv = 1'b1;
    step();
    inv = 1'b0;
    req = '0;
    step();
    chk("shadow_err_set", 32'(err), 32'(SHADOW));
    repeat (5) step();
    chk("shadow_err_sticky", 32'(err), 32'(SHADOW));
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("shadow_err_cleared", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
